// File: rtl/xaui_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xaui_tx_pkg : characters, FSM state and index helpers for the XAUI TX    |
// | column encoder.                                     Revision 1.0         |
// +--------------------------------------------------------------------------+
package xaui_tx_pkg;

  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] K28_0    = 8'h1C;
  localparam logic [7:0] K28_3    = 8'h7C;
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERR   = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;

  // Shared width of the INIT column counter and the ||A|| spacing counter.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2
  } tx_state_t;

  typedef struct packed {
    tx_state_t        state;
    logic [CNT_W-1:0] init_cnt;
    logic [CNT_W-1:0] a_cnt;
    logic             term_seen;
  } tx_ctx_t;

  typedef struct packed {
    tx_ctx_t     ctx;
    logic [31:0] bytes;
    logic [3:0]  k;
    logic        step;
  } col_res_t;

  // Bit offset of (column, lane) on the XGMII side and on the MGT side.
  function automatic int xg_bit(input int col, input int lane);
    return 32 * col + 8 * lane;
  endfunction

  function automatic int mgt_bit(input int col, input int lane);
    return 16 * lane + 8 * col;
  endfunction

  function automatic int k_bit(input int col, input int lane);
    return 2 * lane + col;
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/xaui_tx_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xaui_tx_lfsr : x^7+x^6+1 idle-randomisation LFSR, advances 0..2 steps.   |
// |                                                     Revision 1.0         |
// +--------------------------------------------------------------------------+
module xaui_tx_lfsr
  import xaui_tx_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] step,
  output logic [6:0] cur,
  output logic [6:0] nxt1
);

  logic [6:0] lfsr_state;
  logic [6:0] nxt2;

  assign cur  = lfsr_state;
  assign nxt1 = lfsr_step(lfsr_state);
  assign nxt2 = lfsr_step(nxt1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_state <= SEED;
    end else begin
      case (step)
        2'd1:    lfsr_state <= nxt1;
        2'd2:    lfsr_state <= nxt2;
        default: lfsr_state <= lfsr_state;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/xaui_tx_idle_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xaui_tx_idle_gen : XGMII -> XAUI TX column encoder, two columns / clock. |
// | Optional test-pattern override: XAUI_TX_TESTPAT_EN.  Revision 1.0        |
// +--------------------------------------------------------------------------+
module xaui_tx_idle_gen
  import xaui_tx_pkg::*;
#(
  parameter int         A_MIN     = 16,
  parameter logic [6:0] LFSR_SEED = 7'h7F,
  parameter int         INIT_COLS = 16
) (
  input  logic        xaui_clk,
  input  logic        reset_n,
  input  logic        mgt_tx_rst,
  input  logic [63:0] xgmii_txd,
  input  logic [7:0]  xgmii_txc,
`ifdef XAUI_TX_TESTPAT_EN
  input  logic        tx_testpat_en,
  input  logic        tx_testpat_sel,
`endif
  output logic [63:0] mgt_txdata,
  output logic [7:0]  mgt_txcharisk,
  output logic        tx_a_cnt_zero
);

  tx_ctx_t    ctx;
  tx_ctx_t    ctx_nxt;
  col_res_t   res0;
  col_res_t   res1;
  logic [6:0] lfsr_cur;
  logic [6:0] lfsr_nxt1;
  logic [6:0] lfsr_col1;
  logic [1:0] lfsr_adv;
  logic [63:0] data_nxt;
  logic [7:0]  k_nxt;

  // Returns {bytes, charisk} for a column that is not treated as idle.
  function automatic logic [35:0] encode_data(input logic [31:0] d, input logic [3:0] c);
    logic [31:0] b;
    logic [3:0]  k;
    logic [7:0]  x;
    b = '0;
    k = '0;
    for (int j = 0; j < 4; j++) begin
      x = d[8*j +: 8];
      if (!c[j]) begin
        b[8*j +: 8] = x;
      end else begin
        k[j] = 1'b1;
        case (x)
          XG_IDLE:                          b[8*j +: 8] = K28_5;
          XG_START, XG_TERM, XG_ERR, XG_SEQ: b[8*j +: 8] = x;
          default:                          b[8*j +: 8] = XG_ERR;
        endcase
      end
    end
    return {b, k};
  endfunction

  function automatic col_res_t encode_col(input tx_ctx_t ci, input logic [31:0] d,
                                          input logic [3:0] c, input logic [6:0] lf);
    col_res_t         r;
    logic             idle_col;
    logic             has_term;
    logic [CNT_W-1:0] a_dec;
    r.ctx    = ci;
    r.bytes  = {4{K28_5}};
    r.k      = 4'hF;
    r.step   = 1'b0;
    idle_col = (c == 4'hF) && (d == {4{XG_IDLE}});
    has_term = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (c[j] && (d[8*j +: 8] == XG_TERM)) has_term = 1'b1;
    end
    a_dec = (ci.a_cnt == '0) ? '0 : ci.a_cnt - 1'b1;
    case (ci.state)
      ST_IDLE: begin
        if (idle_col) begin
          r.step          = 1'b1;
          r.ctx.term_seen = 1'b0;
          if (ci.a_cnt == '0) begin
            r.bytes     = {4{K28_3}};
            r.ctx.a_cnt = CNT_W'(A_MIN) + CNT_W'(lf[3:0]);
          end else begin
            r.ctx.a_cnt = a_dec;
            if (!ci.term_seen && lf[0]) r.bytes = {4{K28_0}};
          end
        end else begin
          {r.bytes, r.k} = encode_data(d, c);
          r.ctx.a_cnt    = a_dec;
          r.ctx.state    = ST_DATA;
        end
      end
      ST_DATA: begin
        {r.bytes, r.k} = encode_data(d, c);
        r.ctx.a_cnt    = a_dec;
        if (has_term) begin
          r.ctx.state     = ST_IDLE;
          r.ctx.term_seen = 1'b1;
        end
      end
      default: begin
        r.ctx.term_seen = 1'b0;
        if (ci.init_cnt >= CNT_W'(INIT_COLS - 1)) begin
          r.ctx.state    = ST_IDLE;
          r.ctx.init_cnt = '0;
        end else begin
          r.ctx.state    = ST_INIT;
          r.ctx.init_cnt = ci.init_cnt + 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  xaui_tx_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (xaui_clk),
    .rst_n (reset_n),
    .step  (lfsr_adv),
    .cur   (lfsr_cur),
    .nxt1  (lfsr_nxt1)
  );

  always_comb begin
    res0      = encode_col(ctx, xgmii_txd[31:0], xgmii_txc[3:0], lfsr_cur);
    // col1 sees the LFSR already advanced if col0 consumed an idle step.
    lfsr_col1 = res0.step ? lfsr_nxt1 : lfsr_cur;
    res1      = encode_col(res0.ctx, xgmii_txd[63:32], xgmii_txc[7:4], lfsr_col1);
    ctx_nxt   = res1.ctx;
    lfsr_adv  = {1'b0, res0.step} + {1'b0, res1.step};
    data_nxt  = '0;
    k_nxt     = '0;
    for (int j = 0; j < 4; j++) begin
      data_nxt[mgt_bit(0, j) +: 8] = res0.bytes[8*j +: 8];
      data_nxt[mgt_bit(1, j) +: 8] = res1.bytes[8*j +: 8];
      k_nxt[k_bit(0, j)]           = res0.k[j];
      k_nxt[k_bit(1, j)]           = res1.k[j];
    end
    if (mgt_tx_rst) begin
      // Frame in flight is dropped; a_cnt and the LFSR survive the restart.
      ctx_nxt           = ctx;
      ctx_nxt.state     = ST_INIT;
      ctx_nxt.init_cnt  = '0;
      ctx_nxt.term_seen = 1'b0;
      lfsr_adv          = 2'd0;
      data_nxt          = {8{K28_5}};
      k_nxt             = 8'hFF;
    end
`ifdef XAUI_TX_TESTPAT_EN
    else if (tx_testpat_en && (ctx.state != ST_INIT)) begin
      ctx_nxt  = ctx;
      lfsr_adv = 2'd0;
      data_nxt = tx_testpat_sel ? {8{8'h78}} : {8{8'hB5}};
      k_nxt    = 8'h00;
    end
`endif
  end

  always_ff @(posedge xaui_clk or negedge reset_n) begin
    if (!reset_n) begin
      ctx           <= '{state: ST_INIT, init_cnt: '0, a_cnt: CNT_W'(A_MIN), term_seen: 1'b0};
      mgt_txdata    <= {8{K28_5}};
      mgt_txcharisk <= 8'hFF;
      tx_a_cnt_zero <= 1'b0;
    end else begin
      ctx           <= ctx_nxt;
      mgt_txdata    <= data_nxt;
      mgt_txcharisk <= k_nxt;
      tx_a_cnt_zero <= (ctx_nxt.a_cnt == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xaui_tx_idle_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_xaui_tx_idle_gen : directed self-checking bench for xaui_tx_idle_gen. |
// |                                                     Revision 1.0         |
// +--------------------------------------------------------------------------+
module tb_xaui_tx_idle_gen;

  localparam int CL_K   = 0;
  localparam int CL_R   = 1;
  localparam int CL_A   = 2;
  localparam int CL_BAD = 3;
  localparam logic [63:0] IDLE_D = {8{8'h07}};
  localparam logic [63:0] ALL_K  = {8{8'hBC}};

  logic        xaui_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic        mgt_tx_rst = 1'b0;
  logic [63:0] xgmii_txd = IDLE_D;
  logic [7:0]  xgmii_txc = 8'hFF;
  logic [63:0] mgt_txdata;
  logic [7:0]  mgt_txcharisk;
  logic        tx_a_cnt_zero;
`ifdef XAUI_TX_TESTPAT_EN
  logic        tx_testpat_en  = 1'b0;
  logic        tx_testpat_sel = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  // First 17 idle columns after reset, hand-derived from seed 7F and a_cnt = 16.
  int idle_exp [17] = '{CL_R, CL_K, CL_K, CL_K, CL_K, CL_K, CL_K, CL_R, CL_K,
                        CL_K, CL_K, CL_K, CL_K, CL_R, CL_R, CL_K, CL_A};

  always #5 xaui_clk = ~xaui_clk;

  xaui_tx_idle_gen dut (
    .xaui_clk      (xaui_clk),
    .reset_n       (reset_n),
    .mgt_tx_rst    (mgt_tx_rst),
    .xgmii_txd     (xgmii_txd),
    .xgmii_txc     (xgmii_txc),
`ifdef XAUI_TX_TESTPAT_EN
    .tx_testpat_en (tx_testpat_en),
    .tx_testpat_sel(tx_testpat_sel),
`endif
    .mgt_txdata    (mgt_txdata),
    .mgt_txcharisk (mgt_txcharisk),
    .tx_a_cnt_zero (tx_a_cnt_zero)
  );

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    xgmii_txd = d;
    xgmii_txc = c;
    @(posedge xaui_clk);
    #1;
  endtask

  function automatic int col_class(input int c);
    logic [7:0] b0;
    b0 = mgt_txdata[8*c +: 8];
    for (int j = 0; j < 4; j++) begin
      if (mgt_txcharisk[2*j+c] !== 1'b1) return CL_BAD;
      if (mgt_txdata[16*j+8*c +: 8] !== b0) return CL_BAD;
    end
    case (b0)
      8'hBC:   return CL_K;
      8'h1C:   return CL_R;
      8'h7C:   return CL_A;
      default: return CL_BAD;
    endcase
  endfunction

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge xaui_clk);
    #1;
    checks++;
    if (mgt_txdata !== ALL_K) begin
      errors++; $display("FAIL reset_data got %h exp %h", mgt_txdata, ALL_K);
    end
    checks++;
    if (mgt_txcharisk !== 8'hFF) begin
      errors++; $display("FAIL reset_k got %h exp ff", mgt_txcharisk);
    end
    checks++;
    if (tx_a_cnt_zero !== 1'b0) begin
      errors++; $display("FAIL reset_azero got %b exp 0", tx_a_cnt_zero);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(64'h0807060504030201, 8'h00);
      checks++;
      if (mgt_txdata !== ALL_K || mgt_txcharisk !== 8'hFF) begin
        errors++; $display("FAIL init_k cyc %0d got %h/%h exp %h/ff", i, mgt_txdata, mgt_txcharisk, ALL_K);
      end
    end
  endtask

  task automatic test_idle;
    int last_a = -1;
    int a_seen = 0;
    int ncol, cls, gap;
    for (int n = 0; n < 1000; n++) begin
      drive(IDLE_D, 8'hFF);
      for (int c = 0; c < 2; c++) begin
        cls  = col_class(c);
        ncol = 2 * n + c + 1;
        checks++;
        if (ncol <= 17) begin
          if (cls != idle_exp[ncol-1]) begin
            errors++; $display("FAIL idle_seq col %0d got %0d exp %0d", ncol, cls, idle_exp[ncol-1]);
          end
        end else if (cls == CL_BAD) begin
          errors++; $display("FAIL idle_col col %0d got %h/%h exp K/R/A", ncol, mgt_txdata, mgt_txcharisk);
        end
        if (cls == CL_A) begin
          if (last_a >= 0) begin
            gap = ncol - last_a - 1;
            checks++;
            if (gap < 16 || gap > 31) begin
              errors++; $display("FAIL a_spacing col %0d got %0d exp 16..31", ncol, gap);
            end
            if (a_seen == 1) begin
              checks++;
              if (gap != 28) begin
                errors++; $display("FAIL a_second_gap got %0d exp 28", gap);
              end
            end
          end
          last_a = ncol;
          a_seen++;
        end
      end
      checks++;
      if (col_class(0) == CL_A && col_class(1) == CL_A) begin
        errors++; $display("FAIL double_a cyc %0d got A,A exp at most one", n);
      end
      if (n == 7 || n == 8) begin
        checks++;
        if (tx_a_cnt_zero !== (n == 7)) begin
          errors++; $display("FAIL a_cnt_zero cyc %0d got %b exp %b", n, tx_a_cnt_zero, (n == 7));
        end
      end
    end
    checks++;
    if (a_seen < 60) begin
      errors++; $display("FAIL a_count got %0d exp >=60", a_seen);
    end
  endtask

  task automatic test_frame;
    reset_n = 1'b0;
    @(posedge xaui_clk);
    #1;
    reset_n = 1'b1;
    repeat (8) drive(IDLE_D, 8'hFF);
    drive(64'hD4C3B2A1_555555FB, 8'h01);
    checks++;
    if (mgt_txdata !== 64'hD455_C355_B255_A1FB || mgt_txcharisk !== 8'h01) begin
      errors++; $display("FAIL frame_start got %h/%h exp d455c355b255a1fb/01", mgt_txdata, mgt_txcharisk);
    end
    drive(64'h08120605_04030201, 8'h40);
    checks++;
    if (mgt_txdata !== 64'h0804_FE03_0602_0501 || mgt_txcharisk !== 8'h20) begin
      errors++; $display("FAIL frame_ctrl12 got %h/%h exp 0804fe0306020501/20", mgt_txdata, mgt_txcharisk);
    end
    drive(64'h07070707_070707FD, 8'hFF);
    checks++;
    if (mgt_txdata !== 64'hBCBC_BCBC_BCBC_BCFD || mgt_txcharisk !== 8'hFF) begin
      errors++; $display("FAIL frame_term got %h/%h exp bcbcbcbcbcbcbcfd/ff", mgt_txdata, mgt_txcharisk);
    end
    drive(IDLE_D, 8'hFF);
    checks++;
    if (mgt_txdata !== ALL_K || mgt_txcharisk !== 8'hFF) begin
      errors++; $display("FAIL frame_post_idle got %h/%h exp %h/ff", mgt_txdata, mgt_txcharisk, ALL_K);
    end
  endtask

  task automatic test_ctrl;
    drive(64'h44332211_EEDDCCFB, 8'h01);
    checks++;
    if (mgt_txdata !== 64'h44EE_33DD_22CC_11FB || mgt_txcharisk !== 8'h01) begin
      errors++; $display("FAIL ctrl_start got %h/%h exp 44ee33dd22cc11fb/01", mgt_txdata, mgt_txcharisk);
    end
    drive(64'h33221100_9CFE1207, 8'h0F);
    checks++;
    if (mgt_txdata !== 64'h339C_22FE_11FE_00BC || mgt_txcharisk !== 8'h55) begin
      errors++; $display("FAIL ctrl_mix got %h/%h exp 339c22fe11fe00bc/55", mgt_txdata, mgt_txcharisk);
    end
    drive(64'h07FDAA99_88776655, 8'hC0);
    checks++;
    if (mgt_txdata !== 64'hBC88_FD77_AA66_9955 || mgt_txcharisk !== 8'hA0) begin
      errors++; $display("FAIL ctrl_term_col1 got %h/%h exp bc88fd77aa669955/a0", mgt_txdata, mgt_txcharisk);
    end
    drive(IDLE_D, 8'hFF);
    checks++;
    if (!(col_class(0) == CL_K || col_class(0) == CL_A) || col_class(1) == CL_BAD) begin
      errors++; $display("FAIL ctrl_after_term got %h/%h exp K|A then K/R/A", mgt_txdata, mgt_txcharisk);
    end
  endtask

  task automatic test_mgt_rst;
    drive(64'h44332211_EEDDCCFB, 8'h01);
    mgt_tx_rst = 1'b1;
    drive(64'h0807060504030201, 8'h00);
    checks++;
    if (mgt_txdata !== ALL_K || mgt_txcharisk !== 8'hFF) begin
      errors++; $display("FAIL mgtrst_k got %h/%h exp %h/ff", mgt_txdata, mgt_txcharisk, ALL_K);
    end
    mgt_tx_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(64'h0807060504030201, 8'h00);
      checks++;
      if (mgt_txdata !== ALL_K || mgt_txcharisk !== 8'hFF) begin
        errors++; $display("FAIL mgtrst_init cyc %0d got %h/%h exp %h/ff", i, mgt_txdata, mgt_txcharisk, ALL_K);
      end
    end
    drive(64'h44332211_EEDDCCFB, 8'h01);
    checks++;
    if (mgt_txdata !== 64'h44EE_33DD_22CC_11FB || mgt_txcharisk !== 8'h01) begin
      errors++; $display("FAIL mgtrst_resume got %h/%h exp 44ee33dd22cc11fb/01", mgt_txdata, mgt_txcharisk);
    end
    drive(64'h07070707_070707FD, 8'hFF);
    drive(IDLE_D, 8'hFF);
  endtask

`ifdef XAUI_TX_TESTPAT_EN
  task automatic test_testpat;
    tx_testpat_en  = 1'b1;
    tx_testpat_sel = 1'b0;
    drive(IDLE_D, 8'hFF);
    checks++;
    if (mgt_txdata !== {8{8'hB5}} || mgt_txcharisk !== 8'h00) begin
      errors++; $display("FAIL testpat_hf got %h/%h exp b5../00", mgt_txdata, mgt_txcharisk);
    end
    tx_testpat_sel = 1'b1;
    drive(IDLE_D, 8'hFF);
    checks++;
    if (mgt_txdata !== {8{8'h78}} || mgt_txcharisk !== 8'h00) begin
      errors++; $display("FAIL testpat_mf got %h/%h exp 78../00", mgt_txdata, mgt_txcharisk);
    end
    tx_testpat_en = 1'b0;
    drive(IDLE_D, 8'hFF);
    checks++;
    if (col_class(0) == CL_BAD || col_class(1) == CL_BAD) begin
      errors++; $display("FAIL testpat_resume got %h/%h exp K/R/A", mgt_txdata, mgt_txcharisk);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_frame();
    test_ctrl();
    test_mgt_rst();
`ifdef XAUI_TX_TESTPAT_EN
    test_testpat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
